// File: rtl/audio_meter_pkg.sv
// rtl/audio_meter_pkg.sv - shared types, default constants and magnitude helper for the audio-in level meter
// Contents: rd_state_e read-FSM states, *_DEF parameter defaults, abs_sat saturating magnitude.
package audio_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } rd_state_e;

    localparam int DATA_W_DEF         = 32;
    localparam int NUM_LEDS_DEF       = 13;
    localparam int WINDOW_SAMPLES_DEF = 1024;
    localparam int LED_SHIFT_DEF      = 18;
    localparam int HOLD_WINDOWS_DEF   = 24;

    // Wide enough for any supported sample width; callers sign-extend into it.
    localparam int MAG_MAX_W = 64;

    // |x| of a w-bit sample held sign-extended in x, clamped to 2^(w-1)-1 so the
    // most negative code still fits in w-1 bits.
    function automatic logic [MAG_MAX_W-1:0] abs_sat(input logic [MAG_MAX_W-1:0] x, input int w);
        logic [MAG_MAX_W-1:0] m;
        logic [MAG_MAX_W-1:0] lim;
        lim = (64'd1 << (w - 1)) - 64'd1;
        m   = x[MAG_MAX_W-1] ? (~x + 64'd1) : x;
        if (m > lim) begin
            m = lim;
        end
        return m;
    endfunction

endpackage

// File: rtl/audio_in_level_meter_if.sv
// rtl/audio_in_level_meter_if.sv - audio-in FIFO read port bundle
// master: FIFO side (drives available + L/R data, receives read strobe)
// slave : meter side (samples available + L/R data, drives read strobe)
interface audio_in_level_meter_if #(
    parameter int DATA_W = 32
);
    logic              audio_in_available;
    logic [DATA_W-1:0] left_channel_audio_in;
    logic [DATA_W-1:0] right_channel_audio_in;
    logic              read_audio_in;

    modport master (
        output audio_in_available,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  read_audio_in
    );

    modport slave (
        input  audio_in_available,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output read_audio_in
    );
endinterface

// File: rtl/audio_bar_encoder.sv
// rtl/audio_bar_encoder.sv - level word to thermometer bar and top index, one registered stage
// Ports: clk, reset (sync, active-high), lvl_vld_i/lvl_i level in,
//        bar_o thermometer bar, top_o highest lit index + 1 (0 = none), vld_o lvl_vld_i delayed one cycle.
module audio_bar_encoder #(
    parameter int LVL_W     = 31,
    parameter int NUM_LEDS  = 13,
    parameter int LED_SHIFT = 18,
    parameter int TOP_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lvl_vld_i,
    input  logic [LVL_W-1:0]    lvl_i,
    output logic [NUM_LEDS-1:0] bar_o,
    output logic [TOP_W-1:0]    top_o,
    output logic                vld_o
);
    logic [NUM_LEDS-1:0] bar_d;
    logic [TOP_W-1:0]    top_d;

    always_comb begin
        bar_d = '0;
        top_d = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            bar_d[k] = ((lvl_i >> (LED_SHIFT + k)) != '0);
            if (bar_d[k]) begin
                top_d = TOP_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bar_o <= '0;
            top_o <= '0;
            vld_o <= 1'b0;
        end else begin
            bar_o <= bar_d;
            top_o <= top_d;
            vld_o <= lvl_vld_i;
        end
    end
endmodule

// File: rtl/audio_in_level_meter.sv
// rtl/audio_in_level_meter.sv - audio-in FIFO reader with windowed peak level and LED bar meter
// Optional build macro: AUDIO_METER_PEAK_HOLD_EN adds a held/decaying peak dot on LEDR.
// Ports: CLOCK_50 clock, reset (sync, active-high), enable, channel_sel (00 L, 01 R, 1x max),
//        fifo (slave: available, L/R samples, read strobe), level/level_valid published window max,
//        LEDR bar graph.
module audio_in_level_meter
    import audio_meter_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int NUM_LEDS       = NUM_LEDS_DEF,
    parameter int WINDOW_SAMPLES = WINDOW_SAMPLES_DEF,
    parameter int LED_SHIFT      = LED_SHIFT_DEF,
    parameter int HOLD_WINDOWS   = HOLD_WINDOWS_DEF
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            channel_sel,
    audio_in_level_meter_if.slave fifo,
    output logic [DATA_W-2:0]     level,
    output logic                  level_valid,
    output logic [NUM_LEDS-1:0]   LEDR
);
    localparam int LVL_W  = DATA_W - 1;
    localparam int CNT_W  = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
    localparam int TOP_W  = $clog2(NUM_LEDS + 1);

    // Read FSM: the SETTLE cycle gives the FIFO time to drop its available flag.
    rd_state_e state_q, state_d;
    logic      rd_pop;

    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rd_pop  = 1'b0;
        case (state_q)
            IDLE:    if (enable && fifo.audio_in_available) state_d = POP;
            POP:     begin
                rd_pop  = 1'b1;
                state_d = SETTLE;
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign fifo.read_audio_in = rd_pop;

    // Capture stage: data and channel_sel frozen on the pop cycle.
    logic              cap_vld_q;
    logic [DATA_W-1:0] cap_l_q, cap_r_q;
    logic [1:0]        cap_sel_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cap_vld_q <= 1'b0;
            cap_l_q   <= '0;
            cap_r_q   <= '0;
            cap_sel_q <= '0;
        end else begin
            cap_vld_q <= rd_pop;
            if (rd_pop) begin
                cap_l_q   <= fifo.left_channel_audio_in;
                cap_r_q   <= fifo.right_channel_audio_in;
                cap_sel_q <= channel_sel;
            end
        end
    end

    // Magnitude stage.
    logic [MAG_MAX_W-1:0] abs_l, abs_r;
    logic [LVL_W-1:0]     mag_l, mag_r, mag_d, mag_q;
    logic                 mag_vld_q;
    logic                 unused_abs_hi;

    assign abs_l = abs_sat(MAG_MAX_W'($signed(cap_l_q)), DATA_W);
    assign abs_r = abs_sat(MAG_MAX_W'($signed(cap_r_q)), DATA_W);
    assign mag_l = abs_l[LVL_W-1:0];
    assign mag_r = abs_r[LVL_W-1:0];
    // Upper bits are zero by construction of the saturation.
    assign unused_abs_hi = ^{abs_l[MAG_MAX_W-1:LVL_W], abs_r[MAG_MAX_W-1:LVL_W]};

    always_comb begin
        mag_d = mag_l;
        if (cap_sel_q[1])      mag_d = (mag_l > mag_r) ? mag_l : mag_r;
        else if (cap_sel_q[0]) mag_d = mag_r;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mag_vld_q <= 1'b0;
            mag_q     <= '0;
        end else begin
            mag_vld_q <= cap_vld_q;
            mag_q     <= mag_d;
        end
    end

    // Window stage: the closing sample is folded into the published max.
    logic [CNT_W-1:0] cnt_q;
    logic [LVL_W-1:0] max_q, max_new, level_q;
    logic             level_valid_q;

    assign max_new = (mag_q > max_q) ? mag_q : max_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q         <= '0;
            max_q         <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
        end else begin
            level_valid_q <= 1'b0;
            if (mag_vld_q) begin
                if (cnt_q == CNT_W'(WINDOW_SAMPLES - 1)) begin
                    level_q       <= max_new;
                    level_valid_q <= 1'b1;
                    max_q         <= '0;
                    cnt_q         <= '0;
                end else begin
                    max_q <= max_new;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;

    logic [NUM_LEDS-1:0] enc_bar;
    logic [TOP_W-1:0]    enc_top;
    logic                enc_vld;

    audio_bar_encoder #(
        .LVL_W    (LVL_W),
        .NUM_LEDS (NUM_LEDS),
        .LED_SHIFT(LED_SHIFT),
        .TOP_W    (TOP_W)
    ) u_bar (
        .clk      (CLOCK_50),
        .reset    (reset),
        .lvl_vld_i(level_valid_q),
        .lvl_i    (level_q),
        .bar_o    (enc_bar),
        .top_o    (enc_top),
        .vld_o    (enc_vld)
    );

`ifdef AUDIO_METER_PEAK_HOLD_EN
    localparam int HOLD_W = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;

    logic [TOP_W-1:0]    peak_q, peak_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_LEDS-1:0] dot;

    // Peak tracks the encoder's top index, one update per published window.
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (enc_vld) begin
            if (enc_top > peak_q) begin
                peak_d = enc_top;
                hold_d = '0;
            end else if (hold_q == HOLD_W'(HOLD_WINDOWS - 1)) begin
                if (peak_q != '0) peak_d = peak_q - 1'b1;
                hold_d = '0;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    always_comb begin
        dot = '0;
        if (peak_q != '0) dot = NUM_LEDS'(1) << (peak_q - TOP_W'(1));
        LEDR = enc_bar | dot;
    end
`else
    logic unused_enc;
    assign unused_enc = ^{enc_top, enc_vld};
    assign LEDR       = enc_bar;
`endif

endmodule
